// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch PC controller.
// Optional feature macro used by the top: FETCH_STALL_CNT_EN (stall-cycle counter).
package fetch_pkg;

    // Instruction and address width
    localparam int WORD_W = 32;

    // Default PC loaded on reset
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch controller states
    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        FETCH    = 2'd1,
        HOLD     = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load, clear and hold.
// clear wins over load; clear only drops valid, the data fields keep their last value.
module ifid_reg
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [WORD_W-1:0] npc_in,
    output logic              valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] npc
);

    logic              valid_reg;
    logic [WORD_W-1:0] instr_reg;
    logic [WORD_W-1:0] npc_reg;

    // Pipeline register update: clear > load > hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
            npc_reg   <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            instr_reg <= instr_in;
            npc_reg   <= npc_in;
        end
    end

    assign valid = valid_reg;
    assign instr = instr_reg;
    assign npc   = npc_reg;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: PC register and fetch FSM (RST_WAIT -> FETCH <-> HOLD) feeding the
// IF/ID register. The PC incrementer is external: pc_out goes out, npc_in comes back.
// Define FETCH_STALL_CNT_EN to add the saturating stall_cycles[15:0] output.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [WORD_W-1:0] pc_out,
    input  logic [WORD_W-1:0] npc_in,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              stall,
    input  logic              flush,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              ifid_valid,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_npc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    fetch_state_t      state_reg, state_next;
    logic [WORD_W-1:0] pc_reg, pc_next;
    logic [WORD_W-1:0] hold_instr_reg, hold_instr_next;
    logic [WORD_W-1:0] hold_npc_reg, hold_npc_next;
    logic              ifid_load;
    logic              ifid_clear;
    logic [WORD_W-1:0] ifid_instr_in;
    logic [WORD_W-1:0] ifid_npc_in;

    // State, PC and hold-buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= RST_WAIT;
            pc_reg         <= RESET_PC;
            hold_instr_reg <= '0;
            hold_npc_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            hold_instr_reg <= hold_instr_next;
            hold_npc_reg   <= hold_npc_next;
        end
    end

    // Next-state and datapath decisions; priority branch > flush > stall > ack
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        hold_instr_next = hold_instr_reg;
        hold_npc_next   = hold_npc_reg;
        ifid_load       = 1'b0;
        ifid_clear      = 1'b0;
        ifid_instr_in   = imem_rdata;
        ifid_npc_in     = npc_in;
        if (branch_taken) begin
            pc_next         = branch_target;
            ifid_clear      = 1'b1;
            hold_instr_next = '0;
            hold_npc_next   = '0;
            state_next      = FETCH;
        end else if (flush) begin
            ifid_clear      = 1'b1;
            hold_instr_next = '0;
            hold_npc_next   = '0;
            state_next      = FETCH;
        end else begin
            case (state_reg)
                RST_WAIT: state_next = FETCH;
                FETCH: begin
                    if (imem_ack && !stall) begin
                        ifid_load = 1'b1;
                        pc_next   = npc_in;
                    end else if (imem_ack && stall) begin
                        // Park the returned word until decode can take it
                        hold_instr_next = imem_rdata;
                        hold_npc_next   = npc_in;
                        state_next      = HOLD;
                    end else if (!stall) begin
                        ifid_clear = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_load       = 1'b1;
                        ifid_instr_in   = hold_instr_reg;
                        ifid_npc_in     = hold_npc_reg;
                        pc_next         = hold_npc_reg;
                        hold_instr_next = '0;
                        hold_npc_next   = '0;
                        state_next      = FETCH;
                    end
                end
                default: state_next = RST_WAIT;
            endcase
        end
    end

    // Memory request is issued only while fetching
    always_comb begin
        imem_req = (state_reg == FETCH);
    end

    assign pc_out    = pc_reg;
    assign imem_addr = pc_reg;

    ifid_reg u_ifid_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ifid_load),
        .clear    (ifid_clear),
        .instr_in (ifid_instr_in),
        .npc_in   (ifid_npc_in),
        .valid    (ifid_valid),
        .instr    (ifid_instr),
        .npc      (ifid_npc)
    );

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    // Saturating count of cycles with stall asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed, table-driven bench for fetch_pc_ctrl with the
// incrementer modelled as npc_in = pc_out + 1. Honours FETCH_STALL_CNT_EN.
module tb_fetch_pc_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_out;
    logic [31:0] npc_in;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    // External incrementer
    assign npc_in = pc_out + 32'd1;

    fetch_pc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_out        (pc_out),
        .npc_in        (npc_in),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .flush         (flush),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_npc      (ifid_npc)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    typedef struct {
        logic        br;
        logic [31:0] tgt;
        logic        st;
        logic        fl;
        logic        ack;
        logic [31:0] rd;
        logic [31:0] e_pc;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic br, input logic [31:0] tgt, input logic st,
                                input logic fl, input logic ack, input logic [31:0] rd,
                                input logic [31:0] e_pc, input logic e_req, input logic e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_npc);
        vec_t v;
        v.br = br; v.tgt = tgt; v.st = st; v.fl = fl; v.ack = ack; v.rd = rd;
        v.e_pc = e_pc; v.e_req = e_req; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_npc = e_npc;
        return v;
    endfunction

    task automatic idle_inputs();
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        stall         = 1'b0;
        flush         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_req,
                           input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_npc);
        chk({tag, ".pc"},    pc_out,            e_pc);
        chk({tag, ".addr"},  imem_addr,         e_pc);
        chk({tag, ".req"},   32'(imem_req),     32'(e_req));
        chk({tag, ".valid"}, 32'(ifid_valid),   32'(e_valid));
        chk({tag, ".instr"}, ifid_instr,        e_instr);
        chk({tag, ".npc"},   ifid_npc,          e_npc);
    endtask

    initial begin
        // Sequence starts right after reset release (state RST_WAIT, pc=0)
        //               br tgt            st fl ack rd             e_pc           req val instr          npc
        vecs[0]  = mk(0, 32'h0,        0, 0, 1, 32'hAAAA_AAAA, 32'h0,         1, 0, 32'h0,         32'h0);
        vecs[1]  = mk(0, 32'h0,        0, 0, 1, 32'h1000_0000, 32'h1,         1, 1, 32'h1000_0000, 32'h1);
        vecs[2]  = mk(0, 32'h0,        0, 0, 1, 32'h1000_0001, 32'h2,         1, 1, 32'h1000_0001, 32'h2);
        vecs[3]  = mk(0, 32'h0,        0, 0, 1, 32'h1000_0002, 32'h3,         1, 1, 32'h1000_0002, 32'h3);
        vecs[4]  = mk(0, 32'h0,        0, 0, 0, 32'h0,         32'h3,         1, 0, 32'h1000_0002, 32'h3);
        vecs[5]  = mk(0, 32'h0,        1, 0, 0, 32'h0,         32'h3,         1, 0, 32'h1000_0002, 32'h3);
        vecs[6]  = mk(0, 32'h0,        0, 0, 1, 32'h1000_0003, 32'h4,         1, 1, 32'h1000_0003, 32'h4);
        vecs[7]  = mk(0, 32'h0,        1, 0, 0, 32'h0,         32'h4,         1, 1, 32'h1000_0003, 32'h4);
        vecs[8]  = mk(0, 32'h0,        0, 0, 1, 32'h1000_0004, 32'h5,         1, 1, 32'h1000_0004, 32'h5);
        vecs[9]  = mk(0, 32'h0,        1, 0, 1, 32'hDEAD_BEEF, 32'h5,         0, 1, 32'h1000_0004, 32'h5);
        vecs[10] = mk(0, 32'h0,        1, 0, 1, 32'h0000_0BAD, 32'h5,         0, 1, 32'h1000_0004, 32'h5);
        vecs[11] = mk(0, 32'h0,        1, 0, 0, 32'h0,         32'h5,         0, 1, 32'h1000_0004, 32'h5);
        vecs[12] = mk(0, 32'h0,        0, 0, 1, 32'h0000_BAD2, 32'h6,         1, 1, 32'hDEAD_BEEF, 32'h6);
        vecs[13] = mk(1, 32'h40,       0, 1, 1, 32'h5555_5555, 32'h40,        1, 0, 32'hDEAD_BEEF, 32'h6);
        vecs[14] = mk(0, 32'h0,        0, 1, 1, 32'h6666_6666, 32'h40,        1, 0, 32'hDEAD_BEEF, 32'h6);
        vecs[15] = mk(0, 32'h0,        0, 0, 1, 32'h1000_0005, 32'h41,        1, 1, 32'h1000_0005, 32'h41);
        vecs[16] = mk(1, 32'hFFFF_FFFF,0, 0, 0, 32'h0,         32'hFFFF_FFFF, 1, 0, 32'h1000_0005, 32'h41);
        vecs[17] = mk(0, 32'h0,        0, 0, 1, 32'h1000_0006, 32'h0,         1, 1, 32'h1000_0006, 32'h0);
        vecs[18] = mk(0, 32'h0,        1, 0, 1, 32'h1000_0007, 32'h0,         0, 1, 32'h1000_0006, 32'h0);
        vecs[19] = mk(0, 32'h0,        1, 1, 0, 32'h0,         32'h0,         1, 0, 32'h1000_0006, 32'h0);
        vecs[20] = mk(0, 32'h0,        0, 0, 0, 32'h0,         32'h0,         1, 0, 32'h1000_0006, 32'h0);
        vecs[21] = mk(0, 32'h0,        1, 0, 1, 32'h1000_0008, 32'h0,         0, 0, 32'h1000_0006, 32'h0);
        vecs[22] = mk(1, 32'h100,      1, 0, 0, 32'h0,         32'h100,       1, 0, 32'h1000_0006, 32'h0);
        vecs[23] = mk(0, 32'h0,        1, 0, 1, 32'h1000_0009, 32'h100,       0, 0, 32'h1000_0006, 32'h0);

        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk_all("reset", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_all("reset_clk", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Release away from the edge; RST_WAIT holds imem_req low for one cycle
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_wait.req", 32'(imem_req), 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].tgt;
            stall         = vecs[i].st;
            flush         = vecs[i].fl;
            imem_ack      = vecs[i].ack;
            imem_rdata    = vecs[i].rd;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_req, vecs[i].e_valid,
                    vecs[i].e_instr, vecs[i].e_npc);
            $display("vec %0d: br=%0b st=%0b fl=%0b ack=%0b -> pc=%h req=%0b valid=%0b instr=%h npc=%h",
                     i, vecs[i].br, vecs[i].st, vecs[i].fl, vecs[i].ack,
                     pc_out, imem_req, ifid_valid, ifid_instr, ifid_npc);
        end

        // Asynchronous reset in the middle of HOLD (stall and ack still active)
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        $display("async reset mid-HOLD: pc=%h valid=%0b req=%0b", pc_out, ifid_valid, imem_req);
        @(posedge clk);
        #1;
        chk_all("async_rst_clk", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Re-release: one RST_WAIT cycle, then a clean fetch
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rerelease.req", 32'(imem_req), 32'h0);
        @(posedge clk);
        #1;
        chk("rerelease.req1", 32'(imem_req), 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_0001;
        @(posedge clk);
        #1;
        chk_all("refetch", 32'h1, 1'b1, 1'b1, 32'hCAFE_0001, 32'h1);
        $display("refetch after reset: pc=%h instr=%h npc=%h", pc_out, ifid_instr, ifid_npc);
        idle_inputs();

`ifdef FETCH_STALL_CNT_EN
        // Stall counter: reset clears, counts stall cycles, saturates
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("stallcnt.reset", 32'(stall_cycles), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b1;
        for (int c = 0; c < 10; c++) @(posedge clk);
        #1;
        chk("stallcnt.10", 32'(stall_cycles), 32'd10);
        $display("stall counter after 10 cycles: %0d", stall_cycles);
        for (int c = 10; c < 70000; c++) @(posedge clk);
        #1;
        chk("stallcnt.sat", 32'(stall_cycles), 32'hFFFF);
        $display("stall counter after 70000 cycles: %h", stall_cycles);
        stall = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
